t5_wbarb: RTL and testbench

Bus arbiter and pipeline sequencer for the T5 barrel core. Merges the instruction-fetch port and the data port onto one external Wishbone classic master. Generates the pipeline enable `sena` and pipeline reset `srst` that step the fetch stage and hart rotation. Each pipeline step issues at most one data access followed by one instruction fetch, then pulses `sena`.

---
 rtl/t5_pkg.sv | 23 ++
 rtl/t5_wbarb.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_t5_wbarb.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/t5_pkg.sv
// t5_pkg: shared constants for the T5 bus arbiter / pipeline sequencer.
// Holds the sequencer state encoding, the default reset length and bus
// timeout, and the full-word Wishbone byte-select value.
package t5_pkg;

    // Sequencer states: reset hold, pipeline step, data access, fetch access
    typedef enum logic [1:0] {
        ST_RST  = 2'd0,
        ST_STEP = 2'd1,
        ST_DBUS = 2'd2,
        ST_IBUS = 2'd3
    } wbarb_state_e;

    // Reset hold length: one pipeline reset cycle per hart slot
    localparam int RSTLEN_DEF = 4;

    // Bus timeout in cycles (only meaningful with T5_WBARB_TIMEOUT_EN)
    localparam int TMO_DEF = 255;

    // Wishbone byte select for a full 32-bit word
    localparam logic [3:0] WB_SEL_FULL = 4'hF;

endpackage : t5_pkg

// File: rtl/t5_wbarb.sv
// t5_wbarb: bus arbiter and pipeline sequencer for the T5 barrel core.
//
// Merges the instruction-fetch port and the data port onto one Wishbone
// classic master. Each pipeline step performs at most one data access and
// then at most one fetch, after which sena pulses for one cycle. srst is
// held for RSTLEN cycles after sys_rst is released.
//
// Optional feature macro: T5_WBARB_TIMEOUT_EN
//   defined   - an access with no ack/err for TMO waiting cycles is ended
//               as an error with zero read data.
//   undefined - the arbiter waits for the slave indefinitely.
module t5_wbarb
    import t5_pkg::*;
#(
    parameter int RSTLEN = RSTLEN_DEF,
    parameter int TMO    = TMO_DEF
) (
    input  logic        sclk,
    input  logic        sys_rst,
    // instruction fetch port
    input  logic [29:0] iwb_adr,
    input  logic        iwb_stb,
    output logic [31:0] iwb_dat,
    output logic        iwb_ack,
    output logic        iwb_err,
    // data port
    input  logic [29:0] dwb_adr,
    input  logic [31:0] dwb_dat_o,
    input  logic [3:0]  dwb_sel,
    input  logic        dwb_wre,
    input  logic        dwb_stb,
    output logic [31:0] dwb_dat,
    output logic        dwb_ack,
    output logic        dwb_err,
    // external Wishbone master
    output logic [29:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    // pipeline control
    output logic        sena,
    output logic        srst
);

    localparam int             RCW       = (RSTLEN > 1) ? $clog2(RSTLEN) : 1;
    localparam logic [RCW-1:0] RCNT_LAST = RCW'(RSTLEN - 1);

    wbarb_state_e   state_r;
    wbarb_state_e   state_nxt_s;
    logic [RCW-1:0] rcnt_r;
    logic [RCW-1:0] rcnt_nxt_s;

    // Fetch request and data-valid flag latched on the step edge. The data
    // request itself is latched straight into the bus output registers on
    // that same edge, so it needs no separate copy.
    logic [29:0] iadr_r;
    logic        istb_r;
    logic        dstb_r;

    // Registered bus outputs and their next values
    logic [29:0] wb_adr_r;
    logic [31:0] wb_dat_r;
    logic [3:0]  wb_sel_r;
    logic        wb_we_r;
    logic        wb_cyc_r;
    logic [29:0] adr_nxt_s;
    logic [31:0] dat_nxt_s;
    logic [3:0]  sel_nxt_s;
    logic        we_nxt_s;
    logic        cyc_nxt_s;

    // Registered port responses and pipeline control
    logic [31:0] iwb_dat_r;
    logic        iwb_ack_r;
    logic        iwb_err_r;
    logic [31:0] dwb_dat_r;
    logic        dwb_ack_r;
    logic        dwb_err_r;
    logic        sena_r;
    logic        srst_r;

    logic        bus_busy_s;
    logic        bus_done_s;
    logic        bus_err_s;
    logic [31:0] bus_dat_s;
    logic        tmo_hit_s;

    assign bus_busy_s = (state_r == ST_DBUS) || (state_r == ST_IBUS);

`ifdef T5_WBARB_TIMEOUT_EN
    localparam int TW = ($clog2(TMO + 1) > 8) ? $clog2(TMO + 1) : 8;
    logic [TW-1:0] tmo_cnt_r;

    // Wait counter: cleared on entry to each access, counts waiting cycles
    always_ff @(posedge sclk) begin
        if (sys_rst) begin
            tmo_cnt_r <= {TW{1'b0}};
        end else if (bus_busy_s && (state_nxt_s == state_r)) begin
            tmo_cnt_r <= tmo_cnt_r + {{(TW-1){1'b0}}, 1'b1};
        end else begin
            tmo_cnt_r <= {TW{1'b0}};
        end
    end

    // Timeout fires only when the slave is still silent at the limit
    always_comb begin
        tmo_hit_s = (tmo_cnt_r == TW'(TMO)) && !(wb_ack_i || wb_err_i);
    end
`else
    // No timeout: the slave always terminates the access
    always_comb begin
        tmo_hit_s = 1'b0;
    end
`endif

    // Access termination; ack together with err counts as an error
    always_comb begin
        bus_done_s = wb_ack_i | wb_err_i | tmo_hit_s;
        bus_err_s  = wb_err_i | tmo_hit_s;
        if (tmo_hit_s) begin
            bus_dat_s = 32'h0000_0000;
        end else begin
            bus_dat_s = wb_dat_i;
        end
    end

    // Next-state and next bus-output decode
    always_comb begin
        state_nxt_s = state_r;
        rcnt_nxt_s  = {RCW{1'b0}};
        adr_nxt_s   = 30'h0;
        dat_nxt_s   = 32'h0;
        sel_nxt_s   = 4'h0;
        we_nxt_s    = 1'b0;
        cyc_nxt_s   = 1'b0;
        case (state_r)
            ST_RST: begin
                if (rcnt_r == RCNT_LAST) begin
                    state_nxt_s = ST_STEP;
                end else begin
                    rcnt_nxt_s = rcnt_r + {{(RCW-1){1'b0}}, 1'b1};
                end
            end
            ST_STEP: begin
                if (dwb_stb) begin
                    state_nxt_s = ST_DBUS;
                    adr_nxt_s   = dwb_adr;
                    dat_nxt_s   = dwb_dat_o;
                    sel_nxt_s   = dwb_sel;
                    we_nxt_s    = dwb_wre;
                    cyc_nxt_s   = 1'b1;
                end else if (iwb_stb) begin
                    state_nxt_s = ST_IBUS;
                    adr_nxt_s   = iwb_adr;
                    sel_nxt_s   = WB_SEL_FULL;
                    cyc_nxt_s   = 1'b1;
                end else begin
                    state_nxt_s = ST_STEP;
                end
            end
            ST_DBUS: begin
                if (bus_done_s) begin
                    if (istb_r) begin
                        state_nxt_s = ST_IBUS;
                        adr_nxt_s   = iadr_r;
                        sel_nxt_s   = WB_SEL_FULL;
                        cyc_nxt_s   = 1'b1;
                    end else begin
                        state_nxt_s = ST_STEP;
                    end
                end else begin
                    adr_nxt_s = wb_adr_r;
                    dat_nxt_s = wb_dat_r;
                    sel_nxt_s = wb_sel_r;
                    we_nxt_s  = wb_we_r;
                    cyc_nxt_s = 1'b1;
                end
            end
            ST_IBUS: begin
                if (bus_done_s) begin
                    state_nxt_s = ST_STEP;
                end else begin
                    adr_nxt_s = wb_adr_r;
                    sel_nxt_s = wb_sel_r;
                    cyc_nxt_s = 1'b1;
                end
            end
            default: begin
                state_nxt_s = ST_RST;
            end
        endcase
    end

    // State register and reset-hold counter
    always_ff @(posedge sclk) begin
        if (sys_rst) begin
            state_r <= ST_RST;
            rcnt_r  <= {RCW{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            rcnt_r  <= rcnt_nxt_s;
        end
    end

    // Latch the fetch request and data-valid flag on the step edge
    always_ff @(posedge sclk) begin
        if (sys_rst) begin
            iadr_r <= 30'h0;
            istb_r <= 1'b0;
            dstb_r <= 1'b0;
        end else if (state_r == ST_STEP) begin
            iadr_r <= iwb_adr;
            istb_r <= iwb_stb;
            dstb_r <= dwb_stb;
        end
    end

    // Wishbone master output registers; reset drops cyc on the next edge
    always_ff @(posedge sclk) begin
        if (sys_rst) begin
            wb_adr_r <= 30'h0;
            wb_dat_r <= 32'h0;
            wb_sel_r <= 4'h0;
            wb_we_r  <= 1'b0;
            wb_cyc_r <= 1'b0;
        end else begin
            wb_adr_r <= adr_nxt_s;
            wb_dat_r <= dat_nxt_s;
            wb_sel_r <= sel_nxt_s;
            wb_we_r  <= we_nxt_s;
            wb_cyc_r <= cyc_nxt_s;
        end
    end

    // Capture responses; acks flag the step after a completed access
    always_ff @(posedge sclk) begin
        if (sys_rst) begin
            dwb_dat_r <= 32'h0;
            dwb_err_r <= 1'b0;
            dwb_ack_r <= 1'b0;
            iwb_dat_r <= 32'h0;
            iwb_err_r <= 1'b0;
            iwb_ack_r <= 1'b0;
        end else begin
            if ((state_r == ST_DBUS) && bus_done_s) begin
                dwb_dat_r <= bus_dat_s;
                dwb_err_r <= bus_err_s;
            end
            if ((state_r == ST_IBUS) && bus_done_s) begin
                iwb_dat_r <= bus_dat_s;
                iwb_err_r <= bus_err_s;
            end
            dwb_ack_r <= (state_nxt_s == ST_STEP) && bus_busy_s && dstb_r;
            iwb_ack_r <= (state_nxt_s == ST_STEP) && (state_r == ST_IBUS);
        end
    end

    // Pipeline enable and pipeline reset, registered from the next state
    always_ff @(posedge sclk) begin
        if (sys_rst) begin
            sena_r <= 1'b0;
            srst_r <= 1'b1;
        end else begin
            sena_r <= (state_nxt_s == ST_STEP);
            srst_r <= (state_nxt_s == ST_RST);
        end
    end

    assign wb_adr_o = wb_adr_r;
    assign wb_dat_o = wb_dat_r;
    assign wb_sel_o = wb_sel_r;
    assign wb_we_o  = wb_we_r;
    assign wb_cyc_o = wb_cyc_r;
    assign wb_stb_o = wb_cyc_r;
    assign iwb_dat  = iwb_dat_r;
    assign iwb_ack  = iwb_ack_r;
    assign iwb_err  = iwb_err_r;
    assign dwb_dat  = dwb_dat_r;
    assign dwb_ack  = dwb_ack_r;
    assign dwb_err  = dwb_err_r;
    assign sena     = sena_r;
    assign srst     = srst_r;

endmodule : t5_wbarb

// File: tb/tb_t5_wbarb.sv
// tb_t5_wbarb: directed self-checking bench for t5_wbarb.
// A small Wishbone slave model answers with per-address wait states, error
// address and silent mode; each pipeline step is driven from a sena cycle
// and the bus cycles issued during the step are logged for checking.
module tb_t5_wbarb;

    logic        sclk = 1'b0;
    logic        sys_rst;
    logic [29:0] iwb_adr;
    logic        iwb_stb;
    logic [31:0] iwb_dat;
    logic        iwb_ack;
    logic        iwb_err;
    logic [29:0] dwb_adr;
    logic [31:0] dwb_dat_o;
    logic [3:0]  dwb_sel;
    logic        dwb_wre;
    logic        dwb_stb;
    logic [31:0] dwb_dat;
    logic        dwb_ack;
    logic        dwb_err;
    logic [29:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic [31:0] wb_dat_i = 32'h0;
    logic        wb_ack_i = 1'b0;
    logic        wb_err_i = 1'b0;
    logic        sena;
    logic        srst;

    int checks   = 0;
    int failures = 0;

    // slave model controls
    logic [29:0] slv_slow_adr   = 30'h3FFF_FFFF;
    int          slv_slow_waits = 0;
    logic [29:0] slv_err_adr    = 30'h3FFF_FFFF;
    logic        slv_silent     = 1'b0;
    int          slv_cnt        = 0;

    // per-step bus log
    logic [29:0] log_adr [16];
    logic [31:0] log_dat [16];
    logic [3:0]  log_sel [16];
    logic        log_we  [16];
    int          st_period;
    int          st_cyc;

    t5_wbarb #(.RSTLEN(4), .TMO(8)) dut (
        .sclk(sclk), .sys_rst(sys_rst),
        .iwb_adr(iwb_adr), .iwb_stb(iwb_stb), .iwb_dat(iwb_dat),
        .iwb_ack(iwb_ack), .iwb_err(iwb_err),
        .dwb_adr(dwb_adr), .dwb_dat_o(dwb_dat_o), .dwb_sel(dwb_sel),
        .dwb_wre(dwb_wre), .dwb_stb(dwb_stb), .dwb_dat(dwb_dat),
        .dwb_ack(dwb_ack), .dwb_err(dwb_err),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
        .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
        .sena(sena), .srst(srst)
    );

    // Free-running system clock
    always #5 sclk = ~sclk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] slv_rdata(input logic [29:0] a);
        case (a)
            30'h10:  return 32'h0000_0013;
            30'h200: return 32'h1234_5678;
            default: return {2'b00, a} ^ 32'h5A5A_0000;
        endcase
    endfunction

    // Slave model: responds after the configured waits, back-to-back aware
    always @(negedge sclk) begin
        if (!wb_cyc_o) begin
            slv_cnt  = 0;
            wb_ack_i = 1'b0;
            wb_err_i = 1'b0;
            wb_dat_i = 32'h0;
        end else begin
            if (wb_ack_i || wb_err_i) slv_cnt = 0;
            wb_dat_i = slv_silent ? 32'hFFFF_FFFF : slv_rdata(wb_adr_o);
            if (!slv_silent &&
                slv_cnt == ((wb_adr_o == slv_slow_adr) ? slv_slow_waits : 0)) begin
                wb_ack_i = (wb_adr_o != slv_err_adr);
                wb_err_i = (wb_adr_o == slv_err_adr);
            end else begin
                wb_ack_i = 1'b0;
                wb_err_i = 1'b0;
                slv_cnt++;
            end
        end
    end

    // Issue one step's requests from a sena cycle and run to the next sena
    task automatic run_step(input logic ds, input logic dw, input logic [29:0] da,
                            input logic [31:0] dd, input logic [3:0] dsl,
                            input logic is, input logic [29:0] ia);
        dwb_stb = ds; dwb_wre = dw; dwb_adr = da; dwb_dat_o = dd; dwb_sel = dsl;
        iwb_stb = is; iwb_adr = ia;
        st_period = 0;
        st_cyc    = 0;
        do begin
            @(negedge sclk);
            st_period++;
            dwb_stb = 1'b0;
            iwb_stb = 1'b0;
            if (wb_cyc_o) begin
                if (st_cyc < 16) begin
                    log_adr[st_cyc] = wb_adr_o;
                    log_dat[st_cyc] = wb_dat_o;
                    log_sel[st_cyc] = wb_sel_o;
                    log_we[st_cyc]  = wb_we_o;
                end
                st_cyc++;
            end
        end while (!sena && st_period < 64);
        check_val("step_reaches_sena", {31'b0, sena}, 32'd1);
    endtask

    initial begin
        int n;
        sys_rst = 1'b1;
        iwb_adr = 30'h0; iwb_stb = 1'b0;
        dwb_adr = 30'h0; dwb_dat_o = 32'h0; dwb_sel = 4'h0; dwb_wre = 1'b0; dwb_stb = 1'b0;
        repeat (3) @(negedge sclk);

        // reset state
        check_val("rst_srst", {31'b0, srst}, 32'd1);
        check_val("rst_sena", {31'b0, sena}, 32'd0);
        check_val("rst_cyc", {31'b0, wb_cyc_o}, 32'd0);
        check_val("rst_adr", {2'b0, wb_adr_o}, 32'd0);
        check_val("rst_iack", {31'b0, iwb_ack}, 32'd0);
        check_val("rst_ddat", dwb_dat, 32'd0);

        // reset release: srst for 4 cycles, first sena on cycle 5
        sys_rst = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            @(negedge sclk);
            check_val("rel_srst", {31'b0, srst}, 32'd1);
            check_val("rel_sena", {31'b0, sena}, 32'd0);
        end
        @(negedge sclk);
        check_val("first_sena", {31'b0, sena}, 32'd1);
        check_val("first_srst", {31'b0, srst}, 32'd0);

        // no request: period 1, no bus cycle
        run_step(1'b0, 1'b0, 30'h0, 32'h0, 4'h0, 1'b0, 30'h0);
        check_val("idle_period", st_period, 32'd1);
        check_val("idle_cyc", st_cyc, 32'd0);

        // fetch only, zero-wait
        run_step(1'b0, 1'b0, 30'h0, 32'h0, 4'h0, 1'b1, 30'h10);
        check_val("f_period", st_period, 32'd2);
        check_val("f_ncyc", st_cyc, 32'd1);
        check_val("f_adr", {2'b0, log_adr[0]}, 32'h10);
        check_val("f_we", {31'b0, log_we[0]}, 32'd0);
        check_val("f_sel", {28'b0, log_sel[0]}, 32'hF);
        check_val("f_iack", {31'b0, iwb_ack}, 32'd1);
        check_val("f_idat", iwb_dat, 32'h0000_0013);
        check_val("f_dack", {31'b0, dwb_ack}, 32'd0);

        // store + fetch: data first, then fetch
        run_step(1'b1, 1'b1, 30'h400, 32'hDEADBEEF, 4'h3, 1'b1, 30'h14);
        check_val("sf_period", st_period, 32'd3);
        check_val("sf_ncyc", st_cyc, 32'd2);
        check_val("sf_d_adr", {2'b0, log_adr[0]}, 32'h400);
        check_val("sf_d_we", {31'b0, log_we[0]}, 32'd1);
        check_val("sf_d_sel", {28'b0, log_sel[0]}, 32'h3);
        check_val("sf_d_dat", log_dat[0], 32'hDEADBEEF);
        check_val("sf_i_adr", {2'b0, log_adr[1]}, 32'h14);
        check_val("sf_i_we", {31'b0, log_we[1]}, 32'd0);
        check_val("sf_dack", {31'b0, dwb_ack}, 32'd1);
        check_val("sf_iack", {31'b0, iwb_ack}, 32'd1);
        check_val("sf_idat", iwb_dat, 32'h5A5A_0014);

        // load with 2 wait states, then zero-wait fetch
        slv_slow_adr   = 30'h200;
        slv_slow_waits = 2;
        run_step(1'b1, 1'b0, 30'h200, 32'h0, 4'hF, 1'b1, 30'h10);
        check_val("ld_period", st_period, 32'd5);
        check_val("ld_ncyc", st_cyc, 32'd4);
        check_val("ld_cyc3_adr", {2'b0, log_adr[2]}, 32'h200);
        check_val("ld_fetch_adr", {2'b0, log_adr[3]}, 32'h10);
        check_val("ld_ddat", dwb_dat, 32'h1234_5678);
        check_val("ld_derr", {31'b0, dwb_err}, 32'd0);
        check_val("ld_idat", iwb_dat, 32'h0000_0013);

        // fetch bus error; load data held
        slv_err_adr = 30'h20;
        run_step(1'b0, 1'b0, 30'h0, 32'h0, 4'h0, 1'b1, 30'h20);
        check_val("fe_period", st_period, 32'd2);
        check_val("fe_ierr", {31'b0, iwb_err}, 32'd1);
        check_val("fe_iack", {31'b0, iwb_ack}, 32'd1);
        check_val("fe_dack", {31'b0, dwb_ack}, 32'd0);
        check_val("fe_ddat_held", dwb_dat, 32'h1234_5678);

        // pipeline continues after the error
        run_step(1'b0, 1'b0, 30'h0, 32'h0, 4'h0, 1'b1, 30'h10);
        check_val("fc_period", st_period, 32'd2);
        check_val("fc_ierr", {31'b0, iwb_err}, 32'd0);
        check_val("fc_idat", iwb_dat, 32'h0000_0013);

`ifdef T5_WBARB_TIMEOUT_EN
        // silent slave: each access ends after 8 wait cycles as an error
        slv_silent = 1'b1;
        run_step(1'b1, 1'b0, 30'h40, 32'h0, 4'hF, 1'b1, 30'h44);
        slv_silent = 1'b0;
        check_val("to_period", st_period, 32'd19);
        check_val("to_ncyc", st_cyc, 32'd18);
        check_val("to_derr", {31'b0, dwb_err}, 32'd1);
        check_val("to_ddat", dwb_dat, 32'd0);
        check_val("to_ierr", {31'b0, iwb_err}, 32'd1);
        check_val("to_idat", iwb_dat, 32'd0);
        check_val("to_dack", {31'b0, dwb_ack}, 32'd1);
`endif

        // sys_rst during a data access aborts the cycle at the next edge
        slv_slow_adr   = 30'h300;
        slv_slow_waits = 5;
        dwb_stb = 1'b1; dwb_wre = 1'b1; dwb_adr = 30'h300; dwb_dat_o = 32'hCAFE_F00D;
        dwb_sel = 4'hF; iwb_stb = 1'b1; iwb_adr = 30'h10;
        @(negedge sclk);
        dwb_stb = 1'b0; iwb_stb = 1'b0;
        check_val("ab_cyc_on", {31'b0, wb_cyc_o}, 32'd1);
        check_val("ab_adr", {2'b0, wb_adr_o}, 32'h300);
        sys_rst = 1'b1;
        @(negedge sclk);
        check_val("ab_cyc_off", {31'b0, wb_cyc_o}, 32'd0);
        check_val("ab_srst", {31'b0, srst}, 32'd1);
        check_val("ab_sena", {31'b0, sena}, 32'd0);
        check_val("ab_ddat", dwb_dat, 32'd0);
        sys_rst = 1'b0;
        n = 0;
        do begin
            @(negedge sclk);
            n++;
        end while (!sena && n < 20);
        check_val("ab_rst_len", n, 32'd4);

        // latched requests were discarded: an empty step follows
        run_step(1'b0, 1'b0, 30'h0, 32'h0, 4'h0, 1'b0, 30'h0);
        check_val("ab_after_period", st_period, 32'd1);
        check_val("ab_after_ncyc", st_cyc, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_t5_wbarb
